// File: rtl/axis_packet_framer.sv
// Frames an unframed AXI-Stream byte stream into fixed-length packets with tlast.
// A flush request zero-pads the current partial packet out to full length.
module axis_packet_framer #(
  parameter int packet_length = 8,
  parameter int data_width    = 8,
  parameter int fifo_depth    = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [data_width-1:0]           input_tdata,
  input  logic                            input_tvalid,
  output logic                            input_tready,
  input  logic                            flush,
  output logic [data_width-1:0]           output_tdata,
  output logic                            output_tvalid,
  input  logic                            output_tready,
  output logic                            output_tlast,
  output logic [$clog2(fifo_depth):0]     fifo_count,
  output logic [15:0]                     pkt_count,
  output logic                            fsm_state,
  output logic                            flush_pending
);

  localparam int aw = $clog2(fifo_depth);
  localparam int cw = aw + 1;
  localparam int iw = (packet_length > 1) ? $clog2(packet_length) : 1;

  typedef enum logic {STREAM = 1'b0, PAD = 1'b1} state_t;

  state_t                state, state_next;
  logic [data_width-1:0] mem [fifo_depth];
  logic [cw-1:0]         wr_ptr, rd_ptr;
  logic [iw-1:0]         byte_idx;
  logic                  fifo_full, fifo_empty, slot_free, last_idx;
  logic                  wr_en, rd_en, load, flush_clear;
  logic [data_width-1:0] load_data;

  assign fifo_count = wr_ptr - rd_ptr;
  assign fifo_full  = (fifo_count == cw'(fifo_depth));
  assign fifo_empty = (fifo_count == '0);
  // Gated by reset so every output reads 0 while reset is held.
  assign input_tready = reset_n && !fifo_full;
  assign wr_en      = input_tvalid && !fifo_full;
  assign slot_free  = !output_tvalid || output_tready;
  assign last_idx   = (byte_idx == iw'(packet_length - 1));
  assign fsm_state  = (state == PAD);

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // once valid is high, data/last hold until that transfer completes.
  always_comb begin
    state_next  = state;
    rd_en       = 1'b0;
    load        = 1'b0;
    load_data   = '0;
    flush_clear = 1'b0;
    case (state)
      STREAM: begin
        if (slot_free && !fifo_empty) begin
          rd_en     = 1'b1;
          load      = 1'b1;
          load_data = mem[rd_ptr[aw-1:0]];
        end else if (slot_free && flush_pending) begin
          // Flush is only resolved once every accepted byte has left the FIFO.
          flush_clear = 1'b1;
          if (byte_idx != '0) state_next = PAD;
        end
      end
      PAD: begin
        if (slot_free) begin
          load = 1'b1;
          if (last_idx) state_next = STREAM;
        end
      end
      default: state_next = STREAM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[aw-1:0]] <= input_tdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= STREAM;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      byte_idx      <= '0;
      flush_pending <= 1'b0;
      output_tdata  <= '0;
      output_tvalid <= 1'b0;
      output_tlast  <= 1'b0;
      pkt_count     <= '0;
    end else begin
      state         <= state_next;
      flush_pending <= flush || (flush_pending && !flush_clear);
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (output_tvalid && output_tready && output_tlast) pkt_count <= pkt_count + 16'd1;
      if (load) begin
        output_tdata  <= load_data;
        output_tvalid <= 1'b1;
        output_tlast  <= last_idx;
        byte_idx      <= last_idx ? '0 : byte_idx + 1'b1;
      end else if (output_tready) begin
        output_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axis_packet_framer.md
Name: axis_packet_framer

Overview:
- Upstream framing stage that feeds the byte-packet manipulation stage.
- Accepts an unframed AXI-Stream byte stream into an internal FIFO and emits fixed-length packets of packet_length bytes, with output_tlast on the final byte of each packet.
- A flush request closes a partial packet by zero-padding it to full length, so the downstream stage always sees complete packets.

Parameters:
- packet_length, 8, bytes per output packet (>=2).
- data_width, 8, width of the tdata bus in bits.
- fifo_depth, 16, FIFO entries; power of two, >=2.

Ports:
- clk  input  1  single clock, all logic on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- input_tdata  input  data_width  incoming byte.
- input_tvalid  input  1  incoming byte valid.
- input_tready  output  1  framer can accept a byte.
- flush  input  1  single-cycle pulse: close the current partial packet.
- output_tdata  output  data_width  framed byte.
- output_tvalid  output  1  output byte valid.
- output_tready  input  1  downstream accepts the byte.
- output_tlast  output  1  last byte of a packet.
- fifo_count  output  clog2(fifo_depth)+1  current FIFO occupancy.
- pkt_count  output  16  completed output packets, wraps at 65535->0.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (reset_n).
- Reset values: all outputs 0. FIFO emptied (contents discarded), byte_idx=0, flush_pending=0, state=STREAM.
  - Reset asserted mid-packet aborts the packet. No tlast is generated for it.
- Input side:
  - input_tready = !full (registered-free, derived from occupancy).
  - A write occurs when input_tvalid && input_tready.
  - When full, no write occurs even if a read happens in the same cycle.
- FIFO: circular RAM with read/write pointers one bit wider than the address. Simultaneous read and write leaves fifo_count unchanged.
- Output register (single slot):
  - The slot loads when it is empty, or when it is being consumed this cycle (output_tvalid && output_tready).
  - While output_tvalid && !output_tready, output_tdata and output_tlast hold stable.
  - output_tvalid never drops without a handshake.
- Latency: a byte accepted on edge E appears on output_tvalid/output_tdata from edge E+1, given an empty FIFO and free slot.
  - Throughput is 1 byte/cycle sustained.
- byte_idx: counts bytes loaded into the output slot, from 0 to packet_length-1, then wraps to 0.
  - output_tlast = 1 for the byte loaded with byte_idx = packet_length-1.
  - pkt_count increments on each handshake where output_tlast=1.
- flush:
  - A flush pulse sets flush_pending. A pulse while already pending is absorbed.
  - flush_pending is evaluated when the FIFO is empty and the slot is free or being consumed.
  - At that point, if byte_idx != 0: go to PAD and clear flush_pending.
  - At that point, if byte_idx == 0: clear flush_pending with no output. Empty packets are never generated.
- State STREAM: the slot loads from the FIFO.
- State PAD:
  - The slot loads 0x00 bytes, advancing byte_idx, until the byte with tlast is loaded.
  - After that load, return to STREAM.
  - Input writes continue into the FIFO during PAD. The FIFO is not read in PAD.
- Flush in the same cycle a byte is written: that byte is part of the flushed packet. It is read before padding starts, because the FIFO must be empty first.
- Flush arriving during PAD stays pending. It is evaluated against bytes that arrive later.
- Width rules: all counters wrap modulo their width. No saturation.

Test Plan:
- Steady stream:
  - Stimulus: reset, then 16 bytes 0x01..0x10 with input_tvalid=1 and output_tready=1.
  - Required: 16 bytes out in order, first at edge E+1; tlast on 0x08 and 0x10; pkt_count=2; fifo_count stays <=1.
- Backpressure and full:
  - Stimulus: output_tready=0, push 20 bytes.
  - Required: input_tready drops after 16 FIFO writes plus 1 in the slot; fifo_count=16; output_tdata holds 0x01 stable.
  - Then release output_tready: all 17 accepted bytes out in order, no loss or duplication.
- Flush partial:
  - Stimulus: push 0xA1,0xA2,0xA3, then pulse flush.
  - Required: output A1,A2,A3,00,00,00,00,00; tlast on the 8th byte; pkt_count +1.
- Flush at boundary:
  - Stimulus: pulse flush after exactly 8 bytes are emitted.
  - Required: no padding bytes; flush_pending clears; pkt_count unchanged by the flush.
- Writes during PAD:
  - Stimulus: flush after 1 byte; push 0xB0..0xB2 during padding.
  - Required: 0xB0 is the first byte of the next packet (byte_idx 0), after the padded tlast.
- Async reset:
  - Stimulus: assert reset_n=0 mid-packet, between clock edges.
  - Required: outputs go to 0 immediately; after release, a fresh 8-byte packet frames from byte_idx 0.
